// File: rtl/fixed_to_fp16_pipe.sv
// Two-stage fixed-point (signed/unsigned, any binary point) to IEEE-754 binary16 converter with valid/ready.
// Define FP16_SAT_EN to saturate overflow to the largest finite value instead of infinity.
module fixed_to_fp16_pipe #(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 0,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_data,
  output logic [2:0]      out_flags
);

`ifdef FP16_SAT_EN
  localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
  localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

  logic            s1_valid;
  logic            s1_sign;
  logic            s1_zero;
  logic [IN_W-1:0] s1_mag;
  logic [5:0]      s1_pos;
  logic            s2_load;

  logic            in_sign;
  logic [IN_W-1:0] in_mag;
  logic [5:0]      in_pos;

  logic [5:0]        shamt;
  logic [IN_W+9:0]   ext;
  logic [9:0]        mant;
  logic              guard;
  logic              sticky;
  logic              rnd_up;
  logic [10:0]       mant_sum;
  logic signed [7:0] exp_raw;
  logic signed [7:0] exp_rnd;
  logic [15:0]       res_data;
  logic [2:0]        res_flags;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // Stage 1 front end: sign, magnitude and leading-one position.
  always_comb begin
    in_sign = (SIGNED != 0) ? in_data[IN_W-1] : 1'b0;
    in_mag  = in_sign ? (~in_data + 1'b1) : in_data;
    in_pos  = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (in_mag[i]) in_pos = 6'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_mag   <= '0;
      s1_pos   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_zero <= (in_mag == '0);
        s1_mag  <= in_mag;
        s1_pos  <= in_pos;
      end
    end
  end

  // Normalise so the hidden one falls off the top; the 11 padding zeros cover p < 10.
  always_comb begin
    shamt    = 6'(IN_W - 1) - s1_pos;
    ext      = {(IN_W-1)'(s1_mag << shamt), 11'b0};
    mant     = ext[IN_W+9 -: 10];
    guard    = ext[IN_W-1];
    sticky   = |ext[IN_W-2:0];
    rnd_up   = guard & (sticky | mant[0]);
    mant_sum = {1'b0, mant} + 11'(rnd_up);
    exp_raw  = 8'(s1_pos) - 8'(FRAC_W) + 8'sd15;
    exp_rnd  = exp_raw + 8'(mant_sum[10]);

    if (s1_zero) begin
      res_data  = 16'h0000;
      res_flags = 3'b000;
    end else if (exp_rnd >= 8'sd31) begin
      res_data  = {s1_sign, OVF_MAG};
      res_flags = 3'b101;
    end else if (exp_rnd <= 8'sd0) begin
      res_data  = {s1_sign, 15'b0};
      res_flags = 3'b011;
    end else begin
      res_data  = {s1_sign, exp_rnd[4:0], mant_sum[9:0]};
      res_flags = {2'b00, guard | sticky};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_flags <= 3'b000;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= res_data;
        out_flags <= res_flags;
      end
    end
  end

endmodule

// File: tb/tb_fixed_to_fp16_pipe.sv
// Scoreboard bench for fixed_to_fp16_pipe: three instances (unsigned, signed, all-fraction).
// Expected overflow result follows FP16_SAT_EN.
module tb_fixed_to_fp16_pipe;

  typedef struct {
    logic [18:0] val;
    int          acc;
    bit          exact;
  } exp_t;

`ifdef FP16_SAT_EN
  localparam logic [18:0] OVF_P = {16'h7BFF, 3'b101};
`else
  localparam logic [18:0] OVF_P = {16'h7C00, 3'b101};
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        out_ready = 1'b1;
  logic        in_valid [3];
  logic [15:0] in_data [3];
  logic        in_ready [3];
  logic        out_valid [3];
  logic [15:0] out_data [3];
  logic [2:0]  out_flags [3];

  exp_t exp_q [3][$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   stall_prev = 0;
  logic [18:0] held_val = '0;

  fixed_to_fp16_pipe #(.IN_W(16), .FRAC_W(0), .SIGNED(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_data(out_data[0]), .out_flags(out_flags[0]));

  fixed_to_fp16_pipe #(.IN_W(16), .FRAC_W(0), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_data(out_data[1]), .out_flags(out_flags[1]));

  fixed_to_fp16_pipe #(.IN_W(16), .FRAC_W(16), .SIGNED(0)) u_frac (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_data(out_data[2]), .out_flags(out_flags[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Monitor: pop and compare on every output transfer; also watch output stability while stalled.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n && out_valid[k] && out_ready) begin
        if (exp_q[k].size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word dut%0d: got %h, expected none", k,
                   {out_data[k], out_flags[k]});
        end else begin
          exp_t e;
          e = exp_q[k].pop_front();
          checkOutput($sformatf("dut%0d_word", k), 32'({out_data[k], out_flags[k]}), 32'(e.val));
          if (e.exact) checkOutput($sformatf("dut%0d_latency", k), 32'(cyc - e.acc), 32'd2);
        end
      end
    end
    if (rst_n && stall_prev && out_valid[0])
      checkOutput("stall_hold", 32'({out_data[0], out_flags[0]}), 32'(held_val));
    stall_prev = rst_n && out_valid[0] && !out_ready;
    held_val   = {out_data[0], out_flags[0]};
  end

  task automatic applyStimulus(input int k, input logic [15:0] d, input logic [18:0] e,
                               input bit exact, output int waits);
    bit done;
    done  = 0;
    waits = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    while (!done && waits < 50) begin
      @(negedge clk);
      if (in_ready[k]) begin
        done = 1;
        exp_q[k].push_back('{e, cyc, exact});
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout dut%0d: got no accept, expected accept of %h", k, d);
    end
    in_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0",
               exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      in_data[k]  = '0;
    end
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid[0]), 32'd0);
    checkOutput("rst_out_data", 32'(out_data[0]), 32'h0000);
    checkOutput("rst_out_flags", 32'(out_flags[0]), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready[0]), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Unsigned integer stream, back to back, exact latency.
    applyStimulus(0, 16'h0000, {16'h0000, 3'b000}, 1, w);
    applyStimulus(0, 16'h0001, {16'h3C00, 3'b000}, 1, w);
    applyStimulus(0, 16'h0801, {16'h6800, 3'b001}, 1, w);
    applyStimulus(0, 16'h0803, {16'h6802, 3'b001}, 1, w);
    applyStimulus(0, 16'h00FF, {16'h5BF8, 3'b000}, 1, w);
    applyStimulus(0, 16'hFFFF, OVF_P, 1, w);
    // Signed integers.
    applyStimulus(1, 16'hFFFF, {16'hBC00, 3'b000}, 1, w);
    applyStimulus(1, 16'h8000, {16'hF800, 3'b000}, 1, w);
    applyStimulus(1, 16'h7FFF, {16'h7800, 3'b001}, 1, w);
    applyStimulus(1, 16'h0000, {16'h0000, 3'b000}, 1, w);
    // All-fraction input: underflow and 0.5.
    applyStimulus(2, 16'h0001, {16'h0000, 3'b011}, 1, w);
    applyStimulus(2, 16'h8000, {16'h3800, 3'b000}, 1, w);
    drain();

    // Backpressure: two words fill the pipe, then in_ready must drop.
    out_ready = 1'b0;
    applyStimulus(0, 16'h0001, {16'h3C00, 3'b000}, 0, w);
    applyStimulus(0, 16'h0002, {16'h4000, 3'b000}, 0, w);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h0003;
    @(negedge clk);
    checkOutput("in_ready_full", 32'(in_ready[0]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("in_ready_still_full", 32'(in_ready[0]), 32'd0);
    out_ready = 1'b1;
    applyStimulus(0, 16'h0003, {16'h4200, 3'b000}, 0, w);
    applyStimulus(0, 16'h0004, {16'h4400, 3'b000}, 0, w);
    applyStimulus(0, 16'h0400, {16'h6400, 3'b000}, 0, w);
    drain();

    // Reset with both stages full must clear outputs without a clock edge.
    out_ready = 1'b0;
    applyStimulus(0, 16'h0005, {16'h4500, 3'b000}, 0, w);
    applyStimulus(0, 16'h0006, {16'h4600, 3'b000}, 0, w);
    checkOutput("pre_rst_out_valid", 32'(out_valid[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    checkOutput("mid_rst_out_data", 32'(out_data[0]), 32'h0000);
    checkOutput("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    exp_q[0].delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 16'h0001, {16'h3C00, 3'b000}, 1, w);
    checkOutput("post_rst_first_accept_waits", 32'(w), 32'd0);
    drain();
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fixed_to_fp16_pipe.md
# fixed_to_fp16_pipe

Parametrised, two-stage pipelined converter from a signed or unsigned fixed-point integer to IEEE-754 binary16, with valid/ready handshaking on both sides. It generalises the team's single-width unsigned 16-bit-to-half converter: any input width, a configurable binary point, optional two's-complement input, and status flags. It sits between the integer datapath (pixel and accumulator outputs) and the FP16 processing stages of the CNN accelerator.

## Interface
- IN_W, 16: input word width, legal range 2..32.
- FRAC_W, 0: number of fraction bits in the input, legal range 0..IN_W. The input value is `in_data * 2^-FRAC_W`.
- SIGNED, 0: 1 means `in_data` is two's complement; 0 means it is unsigned.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  `in_data` is valid this cycle.
- in_ready  out  1  the block accepts `in_data` this cycle.
- in_data  in  IN_W  fixed-point input word.
- out_valid  out  1  `out_data` and `out_flags` are valid.
- out_ready  in  1  the downstream block accepts the output.
- out_data  out  16  binary16 result: {sign, exp[4:0], mant[9:0]}.
- out_flags  out  3  {overflow, underflow, inexact}.

## Operation
- Transfer rule: a transfer occurs when valid and ready are both high on the same rising edge, on each side independently.
- Stage 1 (S1) captures the following:
  - Sign: the input MSB when SIGNED=1, otherwise 0.
  - Magnitude: IN_W-bit unsigned. When SIGNED=1 and the input is negative, it is the two's-complement negation; the most negative input yields magnitude 2^(IN_W-1).
  - Zero flag.
  - Leading-one position p, where 0 ≤ p < IN_W.
- Stage 2 (S2) computes the biased exponent `E = p - FRAC_W + 15`, evaluated in signed arithmetic at least 7 bits wide.
- Mantissa, S2:
  - The 10 bits below the leading one form the mantissa.
  - If p < 10, the mantissa is left-aligned and zero-padded.
  - If p > 10, the discarded bits are the guard bit (the first discarded bit) plus the sticky bit (the OR of all remaining discarded bits).
- Rounding is round-to-nearest, ties-to-even:
  - Increment the mantissa if guard=1 and (sticky=1 or mantissa LSB=1).
  - If the mantissa carries out, it becomes 0 and E increments.
- Result selection, in priority order:
  - Zero magnitude: {sign,15'b0}, with flags 000. When SIGNED=1 the sign is always 0 here.
  - E ≥ 31 after rounding: overflow. Result per the Configuration section; flags overflow=1, inexact=1.
  - E ≤ 0: flush to signed zero {sign,15'b0}; flags underflow=1, inexact=1. No subnormals are produced.
  - Otherwise the result is {sign,E[4:0],mant}, with inexact = guard|sticky.
- Ordering: results leave in input order, with no reordering or drops.

## Timing
- Latency: exactly 2 cycles from the input transfer to `out_valid` when there is no backpressure.
- Throughput: 1 word per cycle when `out_ready` is held high.
- Pipeline control:
  - S2 loads when `!out_valid || out_ready`.
  - S1 loads when `!s1_valid || s2_load`.
  - `in_ready = !s1_valid || s2_load`, which is combinational.
- Stall behaviour:
  - When `out_valid=1` and `out_ready=0`, `out_data` and `out_flags` hold stable.
  - With `out_ready` low, at most 2 words are held; `in_ready` falls only when both stages are full.
- Simultaneous events: accepting an input while emitting an output in the same cycle is allowed with no bubble.
- Reset values:
  - `out_valid=0`, `out_data=16'h0000`, `out_flags=3'b000`, and the internal `s1_valid=0`.
  - `in_ready=1` while `rst_n` is low.
- Reset mid-operation: asserting `rst_n` low clears both stages immediately and asynchronously. In-flight words are discarded.
- Post-reset: the first transfer is accepted on the first rising edge after `rst_n` deasserts.

## Configuration
- FP16_SAT_EN:
  - Defined: overflow returns the largest finite value, {sign,15'h7BFF}, i.e. 0x7BFF or 0xFBFF.
  - Undefined: overflow returns infinity, {sign,15'h7C00}, i.e. 0x7C00 or 0xFC00.
- Flags are identical in both builds.

## Test plan
- IN_W=16, FRAC_W=0, SIGNED=0. Inputs 0x0000, 0x0001, 0x0801, 0x0803 are sent back to back with `out_ready=1`. Required outputs, starting 2 cycles later on consecutive cycles:
  - 0x0000 -> 0x0000, flags 000.
  - 0x0001 -> 0x3C00, flags 000.
  - 0x0801 -> 0x6800, flags 001 (tie, rounds to even).
  - 0x0803 -> 0x6802, flags 001 (tie, rounds up to even).
- Same configuration, input 0xFFFF (rounds to 65536):
  - Without the macro: 0x7C00, flags 101.
  - With FP16_SAT_EN: 0x7BFF, flags 101.
- IN_W=16, FRAC_W=0, SIGNED=1:
  - 0xFFFF -> 0xBC00.
  - 0x8000 -> 0xF800, flags 000 (most negative value is exact).
  - 0x7FFF -> 0x7800, flags 001.
- IN_W=16, FRAC_W=16, SIGNED=0:
  - 0x0001 (2^-16) -> 0x0000, flags 011.
  - 0x8000 (0.5) -> 0x3800, flags 000.
- Backpressure:
  - Stream 5 words with `out_ready=0`: `in_ready` drops after 2 words are accepted.
  - Raise `out_ready`: all 5 words emerge in order, outputs are stable while stalled, and there are no duplicates.
- Reset mid-stream: pull `rst_n` low with both stages full. `out_valid` goes 0 and `out_data` goes 0x0000 immediately, without waiting for a clock edge; no stale word appears after release.
